// File: rtl/l1_biu_pkg.sv
// rtl/l1_biu_pkg.sv - shared state encoding, defaults and helpers for the L1 refill bus interface
package l1_biu_pkg;

  // Controller states: three request kinds plus a one-cycle settle after success or abort
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_FILL  = 3'd1,
    ST_SRD   = 3'd2,
    ST_SWR   = 3'd3,
    ST_DONE  = 3'd4,
    ST_FAULT = 3'd5
  } biu_state_t;

  localparam int DEFAULT_ADDR_WIDTH     = 24;
  localparam int DEFAULT_LINE_SIZE      = 128;
  localparam int DEFAULT_TIMEOUT_CYCLES = 255;

  // Offset width within a cache line; LINE_SIZE is a power of two
  function automatic int line_wid_of(input int line_size);
    return $clog2(line_size);
  endfunction

endpackage

// File: rtl/l1_biu_watchdog.sv
// rtl/l1_biu_watchdog.sv - bus watchdog: flags a request left unacknowledged for TIMEOUT_CYCLES cycles
module l1_biu_watchdog #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk,
  input  logic rst,
  input  logic bus_req,
  input  logic bus_ack,
  output logic expired
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] LIMIT = CW'(TIMEOUT_CYCLES);

  logic [CW-1:0] count;

  // Count waiting cycles of an outstanding request; an ack or a dropped request restarts the count
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= '0;
    end else if (!bus_req || bus_ack) begin
      count <= '0;
    end else if (count != LIMIT) begin
      count <= count + 1'b1;
    end
  end

  // Expiry only counts when the bus has not answered in this very cycle
  assign expired = bus_req && !bus_ack && (count == LIMIT);

endmodule

// File: rtl/l1_refill_biu.sv
// rtl/l1_refill_biu.sv - L1-I bus master: line fills, single reads, write-throughs; watchdog under L1_BIU_TIMEOUT_EN
module l1_refill_biu
  import l1_biu_pkg::*;
#(
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int LINE_SIZE      = DEFAULT_LINE_SIZE,
  parameter int LINE_WID       = line_wid_of(LINE_SIZE),
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  read_line_req,
  input  logic                  read_req,
  input  logic                  write_through_req,
  input  logic [ADDR_WIDTH-1:0] pa,
  input  logic [7:0]            wt_data,
  output logic [7:0]            line_data,
  output logic [LINE_WID:0]     addr_count,
  output logic                  line_write,
  output logic                  cache_entry_refill,
  output logic                  trans_rdy,
  output logic                  bus_error,
  output logic                  bus_req,
  output logic                  bus_we,
  output logic [ADDR_WIDTH-1:0] bus_addr,
  output logic [7:0]            bus_wdata,
  input  logic [7:0]            bus_rdata,
  input  logic                  bus_ack,
  input  logic                  bus_err
);

  localparam logic [LINE_WID-1:0] LAST_OFFSET = {LINE_WID{1'b1}};

  biu_state_t          state;
  logic [LINE_WID-1:0] offset;
  logic [LINE_WID-1:0] data_offset;
  logic                ack_seen;
  logic                xfer_ok;
  logic                xfer_fail;
  logic                wd_expired;

  // An ack only means something while a request is actually on the bus
  assign ack_seen   = bus_req && bus_ack;
  assign xfer_ok    = ack_seen && !bus_err;
  assign xfer_fail  = (ack_seen && bus_err) || wd_expired;
  assign addr_count = {1'b0, data_offset};

`ifdef L1_BIU_TIMEOUT_EN
  l1_biu_watchdog #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk     (clk),
    .rst     (rst),
    .bus_req (bus_req),
    .bus_ack (bus_ack),
    .expired (wd_expired)
  );
`else
  logic unused_timeout;
  assign wd_expired     = 1'b0;
  assign unused_timeout = (TIMEOUT_CYCLES != 0);
`endif

  // Request sequencer: bus handshake, fill offset walk and one-cycle result strobes
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state              <= ST_IDLE;
      offset             <= '0;
      data_offset        <= '0;
      line_data          <= '0;
      line_write         <= 1'b0;
      cache_entry_refill <= 1'b0;
      trans_rdy          <= 1'b0;
      bus_error          <= 1'b0;
      bus_req            <= 1'b0;
      bus_we             <= 1'b0;
      bus_addr           <= '0;
      bus_wdata          <= '0;
    end else begin
      line_write         <= 1'b0;
      cache_entry_refill <= 1'b0;
      trans_rdy          <= 1'b0;
      bus_error          <= 1'b0;
      case (state)
        ST_IDLE: begin
          offset <= '0;
          if (read_line_req) begin
            state    <= ST_FILL;
            bus_we   <= 1'b0;
            bus_addr <= {pa[ADDR_WIDTH-1:LINE_WID], {LINE_WID{1'b0}}};
          end else if (read_req) begin
            state    <= ST_SRD;
            bus_we   <= 1'b0;
            bus_addr <= pa;
          end else if (write_through_req) begin
            state     <= ST_SWR;
            bus_we    <= 1'b1;
            bus_addr  <= pa;
            bus_wdata <= wt_data;
          end
        end
        ST_FILL: begin
          if (xfer_fail) begin
            bus_req   <= 1'b0;
            bus_error <= 1'b1;
            state     <= ST_FAULT;
          end else if (xfer_ok) begin
            line_data   <= bus_rdata;
            data_offset <= offset;
            line_write  <= 1'b1;
            if (offset == LAST_OFFSET) begin
              bus_req            <= 1'b0;
              cache_entry_refill <= 1'b1;
              trans_rdy          <= 1'b1;
              state              <= ST_DONE;
            end else begin
              offset                  <= offset + 1'b1;
              bus_addr[LINE_WID-1:0]  <= offset + 1'b1;
            end
          end else if (!bus_req) begin
            bus_req <= 1'b1;
          end
        end
        ST_SRD: begin
          if (xfer_fail) begin
            bus_req   <= 1'b0;
            bus_error <= 1'b1;
            state     <= ST_FAULT;
          end else if (xfer_ok) begin
            bus_req   <= 1'b0;
            line_data <= bus_rdata;
            trans_rdy <= 1'b1;
            state     <= ST_DONE;
          end else if (!bus_req) begin
            bus_req <= 1'b1;
          end
        end
        ST_SWR: begin
          if (xfer_fail) begin
            bus_req   <= 1'b0;
            bus_error <= 1'b1;
            state     <= ST_FAULT;
          end else if (xfer_ok) begin
            bus_req   <= 1'b0;
            trans_rdy <= 1'b1;
            state     <= ST_DONE;
          end else if (!bus_req) begin
            bus_req <= 1'b1;
          end
        end
        ST_DONE, ST_FAULT: begin
          bus_we <= 1'b0;
          state  <= ST_IDLE;
        end
        default: begin
          bus_req <= 1'b0;
          state   <= ST_IDLE;
        end
      endcase
    end
  end

endmodule
